ifetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the instruction cache.
- Owns the PC and drives the cache's fetch request (fetch_able, input_pc); consumes its same-cycle hit/instruction/pc response.
- Predecodes each instruction for next-PC prediction and buffers it in a small FIFO toward the decoder.
- Redirected by the reorder buffer on mispredict/flush.

---
 rtl/ifetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage sitting directly after the instruction cache.
//
// Owns the fetch PC, presents it to the ICache, predecodes every returned word to pick the next
// PC, and buffers {ins, pc, pred_taken, pred_pc} in a small first-word-fall-through queue that
// feeds the decoder. The reorder buffer redirects the stage with flush_in/flush_pc.
//
// Optional build macro: IFU_BHT_EN
//   defined   - conditional branches use a table of 2-bit saturating counters trained by br_upd_*
//   undefined - static backward-taken / forward-not-taken; br_upd_* are ignored
//
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (low freezes every register)
//   fetch_able, input_pc            - fetch request and PC to the ICache
//   hit, hit_ins, ins_pc            - same-cycle ICache response
//   out_valid/out_ins/out_pc/out_pred_taken/out_pred_pc, out_ready - queue head to the decoder
//   flush_in, flush_pc              - redirect from the reorder buffer
//   br_upd_valid/br_upd_pc/br_upd_taken - resolved conditional branch (BHT training)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned IQ_DEPTH_LOG = 2,
  parameter int unsigned BHT_BITS     = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        fetch_able,
  output logic [31:0] input_pc,
  input  logic        hit,
  input  logic [31:0] hit_ins,
  input  logic [31:0] ins_pc,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc,
  input  logic        out_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  input  logic        br_upd_valid,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam int unsigned Depth = 1 << IQ_DEPTH_LOG;
  localparam int unsigned PtrW  = IQ_DEPTH_LOG;
  localparam int unsigned CntW  = IQ_DEPTH_LOG + 1;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] q_ins_q [Depth];
  logic [31:0] q_pc_q  [Depth];
  logic        q_tk_q  [Depth];
  logic [31:0] q_ppc_q [Depth];

  logic        iq_full;
  logic        push;
  logic        pop;
  logic        flush;

  // ---------------------------------------------------------------------------------------------
  // Predecode
  // ---------------------------------------------------------------------------------------------
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic        is_jal;
  logic        is_br;
  logic        br_taken;
  logic        pred_taken;
  logic [31:0] pred_pc;

  assign imm_j  = {{11{hit_ins[31]}}, hit_ins[31], hit_ins[19:12], hit_ins[20],
                   hit_ins[30:21], 1'b0};
  assign imm_b  = {{19{hit_ins[31]}}, hit_ins[31], hit_ins[7], hit_ins[30:25],
                   hit_ins[11:8], 1'b0};
  assign is_jal = (hit_ins[6:0] == OpJal);
  assign is_br  = (hit_ins[6:0] == OpBranch);

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = ins_pc + 32'd4;
    if (is_jal) begin
      pred_taken = 1'b1;
      pred_pc    = ins_pc + imm_j;
    end else if (is_br && br_taken) begin
      pred_taken = 1'b1;
      pred_pc    = ins_pc + imm_b;
    end
  end

`ifdef IFU_BHT_EN
  localparam int unsigned BhtSize = 1 << BHT_BITS;

  logic [1:0]          bht_q [BhtSize];
  logic [BHT_BITS-1:0] lookup_idx;
  logic [BHT_BITS-1:0] upd_idx;
  logic                unused_upd_pc;

  assign lookup_idx    = ins_pc[BHT_BITS+1:2];
  assign upd_idx       = br_upd_pc[BHT_BITS+1:2];
  // Registered read: a same-cycle update at this index is not visible until the next cycle.
  assign br_taken      = bht_q[lookup_idx][1];
  assign unused_upd_pc = ^{br_upd_pc[31:BHT_BITS+2], br_upd_pc[1:0]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BhtSize; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (rdy_in && br_upd_valid) begin
      if (br_upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end
`else
  logic unused_bht;

  // Backward branches (negative offset) are predicted taken.
  assign br_taken   = hit_ins[31];
  assign unused_bht = ^{br_upd_valid, br_upd_pc, br_upd_taken, (BHT_BITS != 32'd0)};
`endif

  // ---------------------------------------------------------------------------------------------
  // Fetch request and queue control
  // ---------------------------------------------------------------------------------------------
  assign iq_full    = (count_q == CntW'(Depth));
  assign flush      = rdy_in && flush_in;
  assign fetch_able = !rst_in && rdy_in && !flush_in && !iq_full;
  assign input_pc   = pc_q;
  assign out_valid  = (count_q != '0);

  // Only accept a response for the PC currently requested; a stale fill still completing after
  // a redirect is dropped here.
  assign push = fetch_able && hit && (ins_pc == pc_q);
  assign pop  = rdy_in && !flush_in && out_valid && out_ready;

  assign out_ins        = q_ins_q[head_q];
  assign out_pc         = q_pc_q[head_q];
  assign out_pred_taken = q_tk_q[head_q];
  assign out_pred_pc    = q_ppc_q[head_q];

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      pc_d    = flush_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pred_pc;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < Depth; i++) begin
        q_ins_q[i] <= '0;
        q_pc_q[i]  <= '0;
        q_tk_q[i]  <= 1'b0;
        q_ppc_q[i] <= '0;
      end
    end else if (push) begin
      q_ins_q[tail_q] <= hit_ins;
      q_pc_q[tail_q]  <= ins_pc;
      q_tk_q[tail_q]  <= pred_taken;
      q_ppc_q[tail_q] <= pred_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run, all checked against a
// queue-based reference model that works from instruction kind/offset rather than bit fields.
module tb_ifetch_unit;

  localparam int unsigned Depth = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_able;
  logic [31:0] input_pc;
  logic        hit;
  logic [31:0] hit_ins;
  logic [31:0] ins_pc;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;
  logic        out_ready;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        br_upd_valid;
  logic [31:0] br_upd_pc;
  logic        br_upd_taken;

  always #5 clk_in = ~clk_in;

  ifetch_unit #(
    .RESET_PC    (32'h0),
    .IQ_DEPTH_LOG(2),
    .BHT_BITS    (6)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .fetch_able    (fetch_able),
    .input_pc      (input_pc),
    .hit           (hit),
    .hit_ins       (hit_ins),
    .ins_pc        (ins_pc),
    .out_valid     (out_valid),
    .out_ins       (out_ins),
    .out_pc        (out_pc),
    .out_pred_taken(out_pred_taken),
    .out_pred_pc   (out_pred_pc),
    .out_ready     (out_ready),
    .flush_in      (flush_in),
    .flush_pc      (flush_pc),
    .br_upd_valid  (br_upd_valid),
    .br_upd_pc     (br_upd_pc),
    .br_upd_taken  (br_upd_taken)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] ppc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  int          m_bht[64];
  int          cur_kind;
  int          cur_off;
  int          n_checks = 0;
  int          n_fail = 0;

  // kind: 0 = addi, 1 = jal, 2 = conditional branch, 3 = jalr
  function automatic logic [31:0] enc(int kind, int off, logic [11:0] salt);
    logic [31:0] o;
    o = off;
    case (kind)
      1:       enc = {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
      2:       enc = {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
      3:       enc = {salt, 5'd1, 3'b000, 5'd1, 7'b1100111};
      default: enc = {salt, 5'd1, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  function automatic ent_t predict(logic [31:0] word, logic [31:0] pc, int kind, int off);
    ent_t e;
    e.ins = word;
    e.pc  = pc;
    e.tk  = 1'b0;
    if (kind == 1) e.tk = 1'b1;
    else if (kind == 2) begin
`ifdef IFU_BHT_EN
      e.tk = (m_bht[int'(pc / 4) % 64] >= 2);
`else
      e.tk = (off < 0);
`endif
    end
    e.ppc = e.tk ? pc + 32'(off) : pc + 32'd4;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic drive(bit rdy, bit h, int kind, int off, bit ordy, bit fl, logic [31:0] fpc,
                       bit stale);
    rdy_in       = rdy;
    hit          = h;
    cur_kind     = kind;
    cur_off      = off;
    hit_ins      = enc(kind, off, 12'($urandom));
    ins_pc       = stale ? m_pc + 32'd8 : m_pc;
    out_ready    = ordy;
    flush_in     = fl;
    flush_pc     = fpc;
    br_upd_valid = 1'b0;
    br_upd_pc    = 32'h0;
    br_upd_taken = 1'b0;
  endtask

  // Advance one clock and apply the same cycle to the model.
  task automatic tick();
    ent_t e;
    bit   do_push;
    bit   do_pop;
    int   idx;
    @(posedge clk_in);
    if (rdy_in) begin
      if (flush_in) begin
        mq.delete();
        m_pc = flush_pc;
      end else begin
        do_push = (mq.size() != Depth) && hit && (ins_pc == m_pc);
        do_pop  = (mq.size() != 0) && out_ready;
        if (do_push) e = predict(hit_ins, ins_pc, cur_kind, cur_off);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back(e);
          m_pc = e.ppc;
        end
      end
`ifdef IFU_BHT_EN
      if (br_upd_valid) begin
        idx = int'(br_upd_pc / 4) % 64;
        if (br_upd_taken && m_bht[idx] < 3) m_bht[idx]++;
        else if (!br_upd_taken && m_bht[idx] > 0) m_bht[idx]--;
      end
`endif
    end
    @(negedge clk_in);
  endtask

  task automatic redirect(logic [31:0] target);
    drive(1, 0, 0, 0, 0, 1, target, 0);
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    drive(1, 1, 0, 0, 1, 0, 32'h0, 0);
    #1;
    model_reset();
    n_checks++;
    if (fetch_able !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch_able: got %b expected 0", fetch_able);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (input_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected 00000000", input_pc);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_fetch_able: got %b expected 1", fetch_able);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      drive(1, k < 3, 0, 0, 1, 0, 32'h0, 0);
      #1;
      n_checks++;
      if (input_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL seq_input_pc[%0d]: got %h expected %h", k, input_pc, 32'(4 * k));
      end
      n_checks++;
      if (out_valid !== (k != 0)) begin
        n_fail++;
        $display("FAIL seq_out_valid[%0d]: got %b expected %b", k, out_valid, k != 0);
      end
      if (k != 0) begin
        n_checks++;
        if (out_pc !== 32'(4 * (k - 1)) || out_pred_pc !== 32'(4 * k) || out_pred_taken !== 0)
        begin
          n_fail++;
          $display("FAIL seq_head[%0d]: got pc %h ppc %h tk %b expected pc %h ppc %h tk 0", k,
                   out_pc, out_pred_pc, out_pred_taken, 32'(4 * (k - 1)), 32'(4 * k));
        end
      end
      tick();
    end
    drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_drained: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_jal();
    drive(1, 0, 0, 0, 0, 1, 32'h10, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_flush_fetch_able: got %b expected 0", fetch_able);
    end
    tick();
    drive(1, 1, 1, 32'h20, 0, 0, 32'h0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (input_pc !== 32'h30) begin
      n_fail++;
      $display("FAIL jal_next_pc: got %h expected 00000030", input_pc);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_ins !== 32'h020000EF ||
        out_pred_taken !== 1'b1 || out_pred_pc !== 32'h30) begin
      n_fail++;
      $display("FAIL jal_entry: got v %b pc %h ins %h tk %b ppc %h expected 1 10 020000ef 1 30",
               out_valid, out_pc, out_ins, out_pred_taken, out_pred_pc);
    end
    tick();
  endtask

  task automatic test_static_branch();
    int          offs[2];
    logic        exp_tk[2];
    logic [31:0] exp_ppc[2];
    offs[0] = -8;
    offs[1] = 16;
`ifdef IFU_BHT_EN
    exp_tk[0] = 1'b0;
    exp_ppc[0] = 32'h44;
`else
    exp_tk[0] = 1'b1;
    exp_ppc[0] = 32'h38;
`endif
    exp_tk[1] = 1'b0;
    exp_ppc[1] = 32'h44;
    for (int i = 0; i < 2; i++) begin
      redirect(32'h40);
      drive(1, 1, 2, offs[i], 0, 0, 32'h0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
      #1;
      n_checks++;
      if (out_pred_taken !== exp_tk[i] || out_pred_pc !== exp_ppc[i] ||
          input_pc !== exp_ppc[i]) begin
        n_fail++;
        $display("FAIL branch_pred[%0d]: got tk %b ppc %h pc %h expected tk %b ppc %h", i,
                 out_pred_taken, out_pred_pc, input_pc, exp_tk[i], exp_ppc[i]);
      end
    end
  endtask

  task automatic test_full();
    redirect(32'h200);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 0, 32'h0, 0);
      #1;
      n_checks++;
      if (fetch_able !== 1'b1 || input_pc !== 32'h200 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: got fa %b pc %h expected 1 %h", i, fetch_able, input_pc,
                 32'h200 + 32'(4 * i));
      end
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b0 || input_pc !== 32'h210) begin
      n_fail++;
      $display("FAIL full_stop: got fa %b pc %h expected 0 00000210", fetch_able, input_pc);
    end
    tick();
    drive(1, 1, 0, 0, 1, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b0 || input_pc !== 32'h210 || out_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL full_pop: got fa %b pc %h head %h expected 0 210 200", fetch_able, input_pc,
               out_pc);
    end
    tick();
    drive(1, 1, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b1 || out_pc !== 32'h204) begin
      n_fail++;
      $display("FAIL full_resume: got fa %b head %h expected 1 00000204", fetch_able, out_pc);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h204 + 32'(4 * j)) begin
        n_fail++;
        $display("FAIL full_order[%0d]: got v %b pc %h expected 1 %h", j, out_valid, out_pc,
                 32'h204 + 32'(4 * j));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    redirect(32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 32'h0, 0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 1, 32'h100, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: got fa %b v %b expected 0 1", fetch_able, out_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || input_pc !== 32'h100) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: got v %b pc %h expected 0 00000100", i, out_valid,
                 input_pc);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    redirect(32'h400);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 0, 32'h0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h40, 1, 1, 32'h500, 0);
      br_upd_valid = 1'b1;
      br_upd_pc    = 32'h400;
      br_upd_taken = 1'b1;
      #1;
      n_checks++;
      if (fetch_able !== 1'b0 || input_pc !== 32'h408 || out_valid !== 1'b1 ||
          out_pc !== 32'h400) begin
        n_fail++;
        $display("FAIL stall[%0d]: got fa %b pc %h v %b head %h expected 0 408 1 400", i,
                 fetch_able, input_pc, out_valid, out_pc);
      end
      tick();
    end
    drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (fetch_able !== 1'b1 || input_pc !== 32'h408 || out_pc !== 32'h400) begin
      n_fail++;
      $display("FAIL stall_release: got fa %b pc %h head %h expected 1 408 400", fetch_able,
               input_pc, out_pc);
    end
    tick();
    drive(1, 0, 0, 0, 1, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h404) begin
      n_fail++;
      $display("FAIL stall_next: got v %b head %h expected 1 00000404", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_bht();
    logic        exp_tk;
    logic [31:0] exp_ppc;
`ifdef IFU_BHT_EN
    exp_tk  = 1'b1;
    exp_ppc = 32'hC0;
`else
    exp_tk  = 1'b0;
    exp_ppc = 32'h84;
`endif
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, i == 0, 32'h80, 0);
      br_upd_valid = 1'b1;
      br_upd_pc    = 32'h80;
      br_upd_taken = 1'b1;
      tick();
    end
    // Lookup and a not-taken update hit the same counter in the same cycle.
    drive(1, 1, 2, 32'h40, 0, 0, 32'h0, 0);
    br_upd_valid = 1'b1;
    br_upd_pc    = 32'h80;
    br_upd_taken = 1'b0;
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (out_pred_taken !== exp_tk || out_pred_pc !== exp_ppc || input_pc !== exp_ppc) begin
      n_fail++;
      $display("FAIL bht_trained: got tk %b ppc %h pc %h expected tk %b ppc %h", out_pred_taken,
               out_pred_pc, input_pc, exp_tk, exp_ppc);
    end
    drive(1, 0, 0, 0, 0, 1, 32'h80, 0);
    br_upd_valid = 1'b1;
    br_upd_pc    = 32'h80;
    br_upd_taken = 1'b0;
    tick();
    drive(1, 1, 2, 32'h40, 0, 0, 32'h0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    n_checks++;
    if (out_pred_taken !== 1'b0 || out_pred_pc !== 32'h84) begin
      n_fail++;
      $display("FAIL bht_untrained: got tk %b ppc %h expected 0 00000084", out_pred_taken,
               out_pred_pc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      int kind;
      int off;
      kind = int'($urandom_range(0, 3));
      off  = (kind == 1) ? (int'($urandom_range(0, 511)) - 256) * 4
                         : (int'($urandom_range(0, 63)) - 32) * 4;
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, kind, off,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
            32'($urandom_range(0, 255)) << 2, $urandom_range(0, 19) == 0);
      br_upd_valid = $urandom_range(0, 2) == 0;
      br_upd_pc    = m_pc + (32'($urandom_range(0, 3)) << 2);
      br_upd_taken = $urandom_range(0, 1) == 1;
      #1;
      n_checks++;
      if (fetch_able !== (rdy_in && !flush_in && mq.size() != Depth)) begin
        n_fail++;
        $display("FAIL rnd_fetch_able[%0d]: got %b expected %b", c, fetch_able,
                 rdy_in && !flush_in && mq.size() != Depth);
      end
      n_checks++;
      if (input_pc !== m_pc) begin
        n_fail++;
        $display("FAIL rnd_input_pc[%0d]: got %h expected %h", c, input_pc, m_pc);
      end
      n_checks++;
      if (out_valid !== (mq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_out_valid[%0d]: got %b expected %b", c, out_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if (out_ins !== mq[0].ins || out_pc !== mq[0].pc || out_pred_taken !== mq[0].tk ||
            out_pred_pc !== mq[0].ppc) begin
          n_fail++;
          $display("FAIL rnd_head[%0d]: got %h %h %b %h expected %h %h %b %h", c, out_ins,
                   out_pc, out_pred_taken, out_pred_pc, mq[0].ins, mq[0].pc, mq[0].tk,
                   mq[0].ppc);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_in = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    test_reset();
    test_sequential();
    test_jal();
    test_static_branch();
    test_full();
    test_flush();
    test_stall();
    test_bht();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
